hazard_stall_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core; it produces the `stall_flag` consumed by the decode-stage control unit (`stall_flag_cu_in`).
- It also drives the PC and IF/ID write enables and the IF/ID flush.
- It detects load-use hazards against the ID/EX stage and taken branches resolved in EX.
- Detection is masked for the cycle after each event. The control unit holds its outputs while stalled, so ID/EX control bits can be stale for one cycle.

---
 rtl/core_pkg.sv | 23 ++
 rtl/sat_counter.sv | 31 +++
 rtl/hazard_stall_ctrl.sv | 96 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, hazard FSM state type and register width for the core
package core_pkg;

   localparam int REG_W_DEF = 5;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] LW    = 6'b000001;
   localparam logic [5:0] SW    = 6'b000010;
   localparam logic [5:0] BEQ   = 6'b000011;
   localparam logic [5:0] ADDI  = 6'b000100;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_BR_FLUSH = 2'd2
   } state_t;

   // LW and ADDI write rt rather than read it; unknown opcodes are treated as rs-only
   function automatic logic uses_rt(input logic [5:0] op);
      return (op == RTYPE) || (op == SW) || (op == BEQ);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that saturates at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall and taken-branch flush control for the 5-stage core
module hazard_stall_ctrl
   import core_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rt,
   input  logic             ex_branch,
   input  logic             ex_branch_taken,
   output logic             stall_flag,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   state_t state_q;
   state_t state_d;
   logic   lu_hazard;
   logic   br_taken;
   logic   stall_inc;
   logic   flush_inc;

   assign lu_hazard = id_valid && ex_mem_read && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (uses_rt(id_opcode) && (ex_rt == id_rt)));
   assign br_taken  = ex_branch && ex_branch_taken;

   always_comb begin
      state_d     = state_q;
      stall_flag  = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      case (state_q)
         // A taken branch wins: the instruction in IF/ID is wrong-path anyway
         ST_IDLE: begin
            if (br_taken) begin
               stall_flag  = 1'b1;
               if_id_flush = 1'b1;
               flush_inc   = 1'b1;
               state_d     = ST_BR_FLUSH;
            end else if (lu_hazard) begin
               stall_flag  = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               stall_inc   = 1'b1;
               state_d     = ST_LU_STALL;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (reset) begin
         state_d     = ST_IDLE;
         stall_flag  = 1'b0;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         stall_inc   = 1'b0;
         flush_inc   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_count)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed vector bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
   import core_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [5:0] id_opcode;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       ex_mem_read;
   logic [4:0] ex_rt;
   logic       ex_branch;
   logic       ex_branch_taken;

   logic        stall_flag, pc_write, if_id_write, if_id_flush;
   logic [15:0] stall_count, flush_count;
   logic        s_stall_flag, s_pc_write, s_if_id_write, s_if_id_flush;
   logic [1:0]  s_stall_count, s_flush_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.REG_W(5), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken),
      .stall_flag(stall_flag), .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_stall_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_branch(ex_branch), .ex_branch_taken(ex_branch_taken),
      .stall_flag(s_stall_flag), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
      .if_id_flush(s_if_id_flush), .stall_count(s_stall_count), .flush_count(s_flush_count)
   );

   typedef struct {
      logic       rst;
      logic       vld;
      logic [5:0] op;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       mrd;
      logic [4:0] ert;
      logic       br;
      logic       tkn;
      logic       e_stall;
      logic       e_pc;
      logic       e_ifw;
      logic       e_fl;
      int         e_sc;
      int         e_fc;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   task automatic check(input string name, input int idx, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h exp=%0h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset           = v.rst;
      id_valid        = v.vld;
      id_opcode       = v.op;
      id_rs           = v.rs;
      id_rt           = v.rt;
      ex_mem_read     = v.mrd;
      ex_rt           = v.ert;
      ex_branch       = v.br;
      ex_branch_taken = v.tkn;
   endtask

   initial begin
      //           rst vld op     rs  rt  mrd ert br tkn  stl pc ifw fl  sc fc
      vecs[0]  = '{1, 0, RTYPE, 0,  0,  0,  0,  0, 0,   0, 0, 0, 1,  0, 0};
      vecs[1]  = '{1, 1, RTYPE, 5,  0,  1,  5,  1, 1,   0, 0, 0, 1,  0, 0};
      vecs[2]  = '{0, 1, RTYPE, 1,  2,  0,  5,  0, 0,   0, 1, 1, 0,  0, 0};
      vecs[3]  = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   1, 0, 0, 0,  0, 0};
      vecs[4]  = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   0, 1, 1, 0,  1, 0};
      vecs[5]  = '{0, 1, RTYPE, 5,  7,  0,  5,  0, 0,   0, 1, 1, 0,  1, 0};
      vecs[6]  = '{0, 1, ADDI,  3,  5,  1,  5,  0, 0,   0, 1, 1, 0,  1, 0};
      vecs[7]  = '{0, 1, SW,    3,  5,  1,  5,  0, 0,   1, 0, 0, 0,  1, 0};
      vecs[8]  = '{0, 1, SW,    3,  5,  1,  5,  0, 0,   0, 1, 1, 0,  2, 0};
      vecs[9]  = '{0, 1, RTYPE, 0,  0,  1,  0,  0, 0,   0, 1, 1, 0,  2, 0};
      vecs[10] = '{0, 0, RTYPE, 5,  5,  1,  5,  0, 0,   0, 1, 1, 0,  2, 0};
      vecs[11] = '{0, 1, BEQ,   1,  5,  1,  5,  0, 0,   1, 0, 0, 0,  2, 0};
      vecs[12] = '{0, 1, BEQ,   1,  5,  1,  5,  0, 0,   0, 1, 1, 0,  3, 0};
      vecs[13] = '{0, 1, 6'h3F, 1,  5,  1,  5,  0, 0,   0, 1, 1, 0,  3, 0};
      vecs[14] = '{0, 1, RTYPE, 5,  7,  1,  5,  1, 1,   1, 1, 1, 1,  3, 0};
      vecs[15] = '{0, 1, RTYPE, 5,  7,  1,  5,  1, 1,   0, 1, 1, 0,  3, 1};
      vecs[16] = '{0, 1, RTYPE, 5,  7,  0,  5,  1, 0,   0, 1, 1, 0,  3, 1};
      vecs[17] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   1, 0, 0, 0,  3, 1};
      vecs[18] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   0, 1, 1, 0,  4, 1};
      vecs[19] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   1, 0, 0, 0,  4, 1};
      vecs[20] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   0, 1, 1, 0,  5, 1};
      vecs[21] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   1, 0, 0, 0,  5, 1};
      vecs[22] = '{1, 1, RTYPE, 5,  7,  1,  5,  0, 0,   0, 0, 0, 1,  6, 1};
      vecs[23] = '{0, 1, RTYPE, 1,  2,  0,  0,  0, 0,   0, 1, 1, 0,  0, 0};
      vecs[24] = '{0, 1, RTYPE, 1,  2,  0,  0,  1, 1,   1, 1, 1, 1,  0, 0};
      vecs[25] = '{1, 1, RTYPE, 1,  2,  0,  0,  1, 1,   0, 0, 0, 1,  0, 1};
      vecs[26] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   1, 0, 0, 0,  0, 0};
      vecs[27] = '{0, 1, RTYPE, 5,  7,  1,  5,  0, 0,   0, 1, 1, 0,  1, 0};

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check("stall_flag",  i, 32'(stall_flag),  32'(vecs[i].e_stall));
         check("pc_write",    i, 32'(pc_write),    32'(vecs[i].e_pc));
         check("if_id_write", i, 32'(if_id_write), 32'(vecs[i].e_ifw));
         check("if_id_flush", i, 32'(if_id_flush), 32'(vecs[i].e_fl));
         check("stall_count", i, 32'(stall_count), vecs[i].e_sc);
         check("flush_count", i, 32'(flush_count), vecs[i].e_fc);
      end

      // Saturation: 2-bit counter sees five load-use stalls and must stick at 3
      @(negedge clk);
      drive('{1, 0, RTYPE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         drive('{0, 1, RTYPE, 5, 7, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0});
         #1;
         check("sat_stall_flag", 100 + i, 32'(s_stall_flag), (i % 2 == 0) ? 1 : 0);
         check("sat_stall_count", 100 + i, 32'(s_stall_count), ((i + 1) / 2 > 3) ? 3 : (i + 1) / 2);
         @(negedge clk);
      end
      drive('{0, 1, RTYPE, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      #1;
      check("sat_final", 110, 32'(s_stall_count), 3);
      check("wide_final", 110, 32'(stall_count), 5);
      check("sat_flush_count", 110, 32'(s_flush_count), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
